// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures live time, lets the user edit
// hour/min/sec fields, then strobes the edited value into the clock counter.
module time_set_ctrl #(
   parameter int PRESET_CYC  = 2,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       mode_i,
   input  logic       inc_i,
   input  logic       dec_i,
   input  logic       cancel_i,
   input  logic [4:0] hour_i,
   input  logic [5:0] min_i,
   input  logic [5:0] sec_i,
   output logic       preset_o,
   output logic [4:0] hour_preset_o,
   output logic [5:0] min_preset_o,
   output logic [5:0] sec_preset_o,
   output logic [9:0] msec_preset_o,
   output logic [1:0] field_o,
   output logic       editing_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      RUN, E_HOUR, E_MIN, E_SEC, COMMIT
   } state_t;

   localparam int IW = $clog2(TIMEOUT_CYC);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC - 1);
   localparam logic [3:0] PC_MAX = 4'(PRESET_CYC - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [3:0]    pc_q, pc_d;
   logic [4:0]    hour_q, hour_d;
   logic [5:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   logic          act, abort, step_up, step_dn;
   logic          preset_d, done_d, editing_d;
   logic [1:0]    field_d;

   assign act     = mode_i | inc_i | dec_i;
   assign abort   = cancel_i | (!act && idle_q == IDLE_MAX);
   assign step_up = inc_i & ~dec_i;
   assign step_dn = dec_i & ~inc_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= RUN;
         idle_q    <= '0;
         pc_q      <= '0;
         hour_q    <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         preset_o  <= 1'b0;
         done_o    <= 1'b0;
         editing_o <= 1'b0;
         field_o   <= 2'd0;
      end else begin
         state_q   <= state_d;
         idle_q    <= idle_d;
         pc_q      <= pc_d;
         hour_q    <= hour_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         preset_o  <= preset_d;
         done_o    <= done_d;
         editing_o <= editing_d;
         field_o   <= field_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      pc_d    = pc_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      unique case (state_q)
         RUN: begin
            if (mode_i) begin
               state_d = E_HOUR;
               idle_d  = '0;
               hour_d  = (hour_i > 5'd23) ? 5'd0 : hour_i;
               min_d   = (min_i > 6'd59) ? 6'd0 : min_i;
               sec_d   = (sec_i > 6'd59) ? 6'd0 : sec_i;
            end
         end
         COMMIT: begin
            if (pc_q == PC_MAX) state_d = RUN;
            else pc_d = pc_q + 4'd1;
         end
         default: begin
            // cancel (or idle timeout) outranks mode, which outranks inc/dec
            if (abort) begin
               state_d = RUN;
               idle_d  = '0;
            end else if (mode_i) begin
               idle_d = '0;
               if (state_q == E_HOUR) state_d = E_MIN;
               else if (state_q == E_MIN) state_d = E_SEC;
               else begin
                  state_d = COMMIT;
                  pc_d    = '0;
               end
            end else begin
               idle_d = act ? '0 : idle_q + IW'(1);
               if (state_q == E_HOUR) begin
                  if (step_up) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                  if (step_dn) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
               end else if (state_q == E_MIN) begin
                  if (step_up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                  if (step_dn) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
               end else begin
                  if (step_up) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                  if (step_dn) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      field_d   = 2'd0;
      editing_d = 1'b0;
      preset_d  = 1'b0;
      done_d    = (state_q == COMMIT) && (state_d == RUN);
      unique case (state_d)
         E_HOUR: begin field_d = 2'd1; editing_d = 1'b1; end
         E_MIN:  begin field_d = 2'd2; editing_d = 1'b1; end
         E_SEC:  begin field_d = 2'd3; editing_d = 1'b1; end
         COMMIT: begin editing_d = 1'b1; preset_d = 1'b1; end
         default: ;
      endcase
   end

   assign hour_preset_o = hour_q;
   assign min_preset_o  = min_q;
   assign sec_preset_o  = sec_q;
   assign msec_preset_o = 10'd0;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: expected outputs are queued as each
// step is driven and popped/compared right after the clock edge.
module tb_time_set_ctrl;

   typedef struct packed {
      logic       pr;
      logic       dn;
      logic       ed;
      logic [1:0] f;
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [9:0] ms;
   } obs_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       mode_i = 1'b0, inc_i = 1'b0, dec_i = 1'b0, cancel_i = 1'b0;
   logic [4:0] hour_i = 5'd12;
   logic [5:0] min_i = 6'd34, sec_i = 6'd56;
   logic       preset_o, editing_o, done_o;
   logic [4:0] hour_preset_o;
   logic [5:0] min_preset_o, sec_preset_o;
   logic [9:0] msec_preset_o;
   logic [1:0] field_o;

   int   nerr = 0;
   int   nchk = 0;
   obs_t exp_q[$];
   string tag_q[$];

   time_set_ctrl #(.PRESET_CYC(2), .TIMEOUT_CYC(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mode_i(mode_i), .inc_i(inc_i), .dec_i(dec_i), .cancel_i(cancel_i),
      .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
      .preset_o(preset_o),
      .hour_preset_o(hour_preset_o), .min_preset_o(min_preset_o),
      .sec_preset_o(sec_preset_o), .msec_preset_o(msec_preset_o),
      .field_o(field_o), .editing_o(editing_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic obs_t mk(logic pr, logic dn, logic ed, logic [1:0] f,
                               logic [4:0] h, logic [5:0] m, logic [5:0] s);
      obs_t o;
      o.pr = pr; o.dn = dn; o.ed = ed; o.f = f;
      o.h = h; o.m = m; o.s = s; o.ms = 10'd0;
      return o;
   endfunction

   task automatic step(string tag, logic m, logic i, logic d, logic c,
                       logic r, obs_t e);
      obs_t o, x;
      string t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk_i);
      mode_i = m; inc_i = i; dec_i = d; cancel_i = c; rst_i = r;
      @(posedge clk_i);
      #1;
      mode_i = 0; inc_i = 0; dec_i = 0; cancel_i = 0; rst_i = 1;
      o = '{preset_o, done_o, editing_o, field_o, hour_preset_o,
            min_preset_o, sec_preset_o, msec_preset_o};
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      nchk++;
      assert (o === x) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", t, o, x);
      end
   endtask

   initial begin
      // reset
      step("rst0", 0,0,0,0,0, mk(0,0,0,0,0,0,0));
      step("rst1", 0,0,0,0,0, mk(0,0,0,0,0,0,0));

      // capture, edit and commit 12:34:56 -> 14:33:56
      step("cap",    1,0,0,0,1, mk(0,0,1,1,12,34,56));
      step("inc_h1", 0,1,0,0,1, mk(0,0,1,1,13,34,56));
      step("inc_h2", 0,1,0,0,1, mk(0,0,1,1,14,34,56));
      step("to_min", 1,0,0,0,1, mk(0,0,1,2,14,34,56));
      step("dec_m",  0,0,1,0,1, mk(0,0,1,2,14,33,56));
      step("to_sec", 1,0,0,0,1, mk(0,0,1,3,14,33,56));
      step("commit", 1,0,0,0,1, mk(1,0,1,0,14,33,56));
      step("pre2",   0,1,0,1,1, mk(1,0,1,0,14,33,56));
      step("done",   0,0,0,0,1, mk(0,1,0,0,14,33,56));
      step("post",   0,0,0,0,1, mk(0,0,0,0,14,33,56));

      // RUN ignores inc/dec/cancel
      step("run_inc", 0,1,0,0,1, mk(0,0,0,0,14,33,56));
      step("run_dec", 0,0,1,0,1, mk(0,0,0,0,14,33,56));
      step("run_can", 0,0,0,1,1, mk(0,0,0,0,14,33,56));

      // wrap-around
      hour_i = 5'd23; min_i = 6'd0; sec_i = 6'd59;
      step("w_cap",  1,0,0,0,1, mk(0,0,1,1,23,0,59));
      step("w_hinc", 0,1,0,0,1, mk(0,0,1,1,0,0,59));
      step("w_hdec", 0,0,1,0,1, mk(0,0,1,1,23,0,59));
      step("w_hin2", 0,1,0,0,1, mk(0,0,1,1,0,0,59));
      step("w_min",  1,0,0,0,1, mk(0,0,1,2,0,0,59));
      step("w_mdec", 0,0,1,0,1, mk(0,0,1,2,0,59,59));
      step("w_sec",  1,0,0,0,1, mk(0,0,1,3,0,59,59));
      step("w_sinc", 0,1,0,0,1, mk(0,0,1,3,0,59,0));
      step("w_can",  0,0,0,1,1, mk(0,0,0,0,0,59,0));

      // clamp of out-of-range live time
      hour_i = 5'd30; min_i = 6'd60; sec_i = 6'd63;
      step("clamp", 1,0,0,0,1, mk(0,0,1,1,0,0,0));
      step("cl_can", 0,0,0,1,1, mk(0,0,0,0,0,0,0));

      // cancel in E_MIN, then 20 quiet cycles
      hour_i = 5'd5; min_i = 6'd6; sec_i = 6'd7;
      step("c_cap", 1,0,0,0,1, mk(0,0,1,1,5,6,7));
      step("c_min", 1,0,0,0,1, mk(0,0,1,2,5,6,7));
      step("c_can", 0,0,0,1,1, mk(0,0,0,0,5,6,7));
      for (int k = 0; k < 20; k++)
         step("c_quiet", 0,0,0,0,1, mk(0,0,0,0,5,6,7));

      // idle timeout after 16 cycles
      hour_i = 5'd1; min_i = 6'd2; sec_i = 6'd3;
      step("t_cap", 1,0,0,0,1, mk(0,0,1,1,1,2,3));
      for (int k = 1; k < 16; k++)
         step("t_wait", 0,0,0,0,1, mk(0,0,1,1,1,2,3));
      step("t_out", 0,0,0,0,1, mk(0,0,0,0,1,2,3));
      for (int k = 0; k < 4; k++)
         step("t_quiet", 0,0,0,0,1, mk(0,0,0,0,1,2,3));

      // same-cycle events
      hour_i = 5'd10; min_i = 6'd20; sec_i = 6'd30;
      step("s_cap",  1,0,0,0,1, mk(0,0,1,1,10,20,30));
      step("s_mi",   1,1,0,0,1, mk(0,0,1,2,10,20,30));
      step("s_id",   0,1,1,0,1, mk(0,0,1,2,10,20,30));
      step("s_cm",   1,0,0,1,1, mk(0,0,0,0,10,20,30));
      step("s_quiet", 0,0,0,0,1, mk(0,0,0,0,10,20,30));

      // reset in first preset cycle
      hour_i = 5'd8; min_i = 6'd9; sec_i = 6'd10;
      step("r_cap", 1,0,0,0,1, mk(0,0,1,1,8,9,10));
      step("r_min", 1,0,0,0,1, mk(0,0,1,2,8,9,10));
      step("r_sec", 1,0,0,0,1, mk(0,0,1,3,8,9,10));
      step("r_com", 1,0,0,0,1, mk(1,0,1,0,8,9,10));
      step("r_rst", 0,0,0,0,0, mk(0,0,0,0,0,0,0));
      step("r_nd1", 0,0,0,0,1, mk(0,0,0,0,0,0,0));
      step("r_nd2", 0,0,0,0,1, mk(0,0,0,0,0,0,0));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter PRESET_CYC, default 2, number of cycles preset_o is held high on commit (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, number of idle edit cycles before automatic abort (minimum 4).
REQ-003 SHALL have port clk_i  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port mode_i  in  1  single-cycle pulse: enter edit / advance field / commit.
REQ-006 SHALL have port inc_i  in  1  single-cycle pulse: increment selected field.
REQ-007 SHALL have port dec_i  in  1  single-cycle pulse: decrement selected field.
REQ-008 SHALL have port cancel_i  in  1  single-cycle pulse: abort edit.
REQ-009 SHALL have ports hour_i / min_i / sec_i  in  5/6/6  live time from the clock counter.
REQ-010 SHALL have port preset_o  out  1  load strobe to the clock counter's preset input.
REQ-011 SHALL have ports hour_preset_o / min_preset_o / sec_preset_o / msec_preset_o  out  5/6/6/10  preset values.
REQ-012 SHALL have port field_o  out  2  selected field: 0 none, 1 hour, 2 min, 3 sec.
REQ-013 SHALL have port editing_o  out  1  high in any edit state.
REQ-014 SHALL have port done_o  out  1  one-cycle pulse when a commit finishes.

Function
REQ-015 SHALL implement FSM states RUN, E_HOUR, E_MIN, E_SEC, COMMIT.
REQ-016 In RUN, mode_i SHALL copy hour_i/min_i/sec_i into the edit registers and enter E_HOUR on the next edge.
REQ-017 In RUN, inc_i, dec_i and cancel_i SHALL be ignored.
REQ-018 mode_i SHALL advance E_HOUR->E_MIN->E_SEC->COMMIT, one state per pulse.
REQ-019 inc_i SHALL add 1 to the selected field modulo 24 (hour) or 60 (min/sec): 23->0, 59->0.
REQ-020 dec_i SHALL subtract 1 modulo the same range: 0->23 (hour), 0->59 (min/sec).
REQ-021 Simultaneous inc_i and dec_i SHALL leave the field unchanged.
REQ-022 Priority in edit states SHALL be cancel_i > mode_i > inc_i/dec_i; a lower-priority pulse in the same cycle is discarded.
REQ-023 cancel_i in E_HOUR/E_MIN/E_SEC SHALL return to RUN with no preset_o pulse.
REQ-024 The idle counter SHALL clear on any mode_i/inc_i/dec_i in edit states; reaching TIMEOUT_CYC SHALL act as cancel_i.
REQ-025 COMMIT SHALL hold preset_o=1 for exactly PRESET_CYC cycles, starting the cycle after the E_SEC mode_i edge, then enter RUN.
REQ-026 done_o SHALL pulse for one cycle, coincident with the first RUN cycle after COMMIT.
REQ-027 All inputs except rst_i SHALL be ignored in COMMIT.
REQ-028 hour/min/sec_preset_o SHALL continuously drive the edit registers; msec_preset_o SHALL be constant 0.
REQ-029 field_o SHALL be 1/2/3 in E_HOUR/E_MIN/E_SEC, 0 in RUN and COMMIT.
REQ-030 editing_o SHALL be 1 in E_HOUR/E_MIN/E_SEC/COMMIT, else 0.
REQ-031 Captured hour_i>23 or min_i/sec_i>59 SHALL be clamped to 0 on capture.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst_i=0 at a clock edge SHALL force RUN, edit registers 0, idle counter 0, preset_o=0, done_o=0, field_o=0, editing_o=0.
REQ-034 Reset during COMMIT SHALL terminate preset_o on that edge; no done_o SHALL follow.

Verification
REQ-035 Bench SHALL cover capture and commit: live 12:34:56, mode, inc x2, mode, dec, mode, mode -> preset_o high 2 cycles with 14/33/56, msec 0, then done_o.
REQ-036 Bench SHALL cover wrap: hour 23 inc -> 0; min 0 dec -> 59; sec 59 inc -> 0.
REQ-037 Bench SHALL cover cancel: cancel_i in E_MIN -> RUN, field_o=0, no preset_o for 20 cycles.
REQ-038 Bench SHALL cover timeout: TIMEOUT_CYC=16, no input after entering E_HOUR -> RUN 16 cycles later, no preset_o.
REQ-039 Bench SHALL cover same-cycle events: mode_i+inc_i in E_HOUR -> E_MIN, hour unchanged; inc_i+dec_i -> unchanged; cancel_i+mode_i -> RUN.
REQ-040 Bench SHALL cover reset mid-COMMIT: rst_i low in the first preset cycle -> preset_o 0 on next edge, all outputs at reset values, no done_o.
